icache: RTL and testbench
=========================

// Module: icache
//
// PURPOSE
// Direct-mapped, read-only instruction cache. Responder on the fetch-queue request interface.
// - Returns one aligned 128-bit line (4 instructions) per accepted request.
// - Hits complete in the same cycle as the request; misses complete after a 4-beat refill from memory.
// - Sits between the instruction fetch queue and the instruction memory port.
//
// PARAMETERS
// INDEX_BITS   6    line index width; cache holds 2**INDEX_BITS lines of 16 bytes
//
// PORTS
// clk                 in   1    clock, all state on rising edge
// reset               in   1    asynchronous, active-low reset
// icache_pc_in        in   32   fetch address; bits [3:0] ignored
// icache_rd_en        in   1    fetch request, level; held by requester until icache_dout_valid
// icache_abort        in   1    branch redirect; cancels the current request this cycle
// icache_dout         out  128  line data; word0 = [31:0] = lowest address
// icache_dout_valid   out  1    icache_dout valid for icache_pc_in this cycle
// mem_rd_req          out  1    refill request, held until mem_rd_ack
// mem_rd_addr         out  32   refill line address {pc[31:4],4'b0}; stable while mem_rd_req=1
// mem_rd_ack          in   1    memory accepted refill request
// mem_rd_data         in   32   refill beat, word0 first
// mem_rd_data_valid   in   1    beat valid; exactly 4 beats per ack, gaps allowed
//
// BEHAVIOUR
// - Reset (reset=0): all valid bits cleared; FSM=IDLE; beat counter=0; aborted flag=0.
//   Outputs: icache_dout_valid=0, mem_rd_req=0, mem_rd_addr=0.
//   icache_dout is don't-care but X-free (arrays reset to 0).
// - Address split: offset=pc[3:0], index=pc[4+INDEX_BITS-1:4], tag=pc[31:4+INDEX_BITS].
// - Lookup: combinational against registered tag/valid/data arrays.
//   hit = valid[index] & (tag_r[index]==tag).
// - icache_dout_valid = (state==IDLE) & icache_rd_en & ~icache_abort & hit.
//   This gives zero-cycle hit latency and one line per cycle on consecutive hits.
// - icache_abort has priority over icache_rd_en in the same cycle: no hit reported, no miss started.
// - FSM:
//   - IDLE -> REQ: on rd_en & ~abort & ~hit. Latch the line address into mem_rd_addr; assert mem_rd_req.
//   - REQ -> FILL: on mem_rd_ack. mem_rd_req drops the next cycle. The request is never withdrawn.
//   - FILL: each mem_rd_data_valid writes word[beat] into the line buffer; the 2-bit counter increments.
//   - FILL -> IDLE: on the 4th beat. Write data, tag and valid[index]=1 at that edge. Clear the counter.
// - Abort while REQ/FILL: set the aborted flag.
//   - The refill still runs to completion and the line is still installed.
//   - dout_valid is never asserted for the aborted line's request; the flag clears on return to IDLE.
// - No hit-under-miss: icache_dout_valid=0 whenever state!=IDLE.
// - After the fill, the requester (still presenting the pc) hits on the first IDLE cycle:
//   fill-to-data latency is 1 cycle after the 4th beat.
// - Conflict eviction: a fill overwrites whatever line occupies the index; no writeback (read-only).
// - mem_rd_data_valid outside FILL is ignored.
// - Asynchronous reset mid-refill returns to IDLE immediately.
//   Memory-side drain is the memory controller's responsibility, and it is reset by the same signal.
//
// CONFIGURATION
// ICACHE_FILL_BYPASS_EN
// - Defined: in the cycle of the 4th beat, if the aborted flag is clear, icache_rd_en=1, ~icache_abort,
//   and pc[31:4] equals the fill address:
//   - icache_dout = {mem_rd_data, buffer[2:0]} and icache_dout_valid=1, saving one cycle.
//   - The install happens as normal.
// - Undefined: no bypass; the data is returned via a hit on the following IDLE cycle.
//
// STRUCTURE
// - Shared include icache_defs.vh:
//   - FSM state encodings: IDLE, REQ, FILL.
//   - LINE_BYTES=16, WORDS_PER_LINE=4.
//   - Tag/index/offset field position defines.
// - Sub-module icache_fill_ctrl: FSM, beat counter, line buffer, aborted flag, mem_* handshake.
//   It exports fill_done, fill_line, fill_addr.
// - Top level holds the tag/valid/data arrays and the hit logic.
//
// TESTING
// 1. Cold miss: rd_en=1, pc=0x0000_0040.
//    -> mem_rd_req=1, mem_rd_addr=0x40.
//    -> After ack and beats 0x11,0x22,0x33,0x44, dout_valid the next cycle,
//       icache_dout=0x00000044_00000033_00000022_00000011.
// 2. Hit streaming: after line 0x40 and line 0x50 are installed, present pc 0x40 then 0x50
//    on consecutive cycles -> dout_valid=1 both cycles, no mem_rd_req.
// 3. Abort mid-fill: miss on 0x100, assert abort after beat 1.
//    -> All 4 beats are accepted; dout_valid stays 0 through the fill.
//    -> A later request for 0x100 hits with no new mem_rd_req.
// 4. Conflict: INDEX_BITS=6, install 0x0000_0040, then request 0x0000_0440 (same index).
//    -> Miss and refill; a subsequent request for 0x40 misses again.
// 5. Same-cycle rd_en+abort on a resident line -> dout_valid=0, state stays IDLE.
// 6. Async reset asserted during FILL at beat 2.
//    -> mem_rd_req=0, dout_valid=0 immediately.
//    -> After release, the prior-hit address 0x40 misses.
//    With ICACHE_FILL_BYPASS_EN, scenario 1 returns dout_valid in the 4th-beat cycle.

Source files
------------

// File: rtl/icache_pkg.sv
// icache shared definitions: line geometry and refill FSM states.
// Imported by icache and icache_fill_ctrl.
package icache_pkg;

    localparam int LINE_BYTES     = 16;
    localparam int WORDS_PER_LINE = 4;
    localparam int OFF_BITS       = $clog2(LINE_BYTES);
    localparam int LINE_BITS      = 32 * WORDS_PER_LINE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FILL = 2'd2
    } fill_state_e;

endpackage

// File: rtl/icache_if.sv
// icache handshake bundles: fetch-queue request side and memory refill side.
// master drives the request; slave answers it.
interface icache_fetch_if;
    logic [31:0]  icache_pc_in;
    logic         icache_rd_en;
    logic         icache_abort;
    logic [127:0] icache_dout;
    logic         icache_dout_valid;

    modport master (
        output icache_pc_in, icache_rd_en, icache_abort,
        input  icache_dout, icache_dout_valid
    );
    modport slave (
        input  icache_pc_in, icache_rd_en, icache_abort,
        output icache_dout, icache_dout_valid
    );
endinterface

interface icache_mem_if;
    logic        mem_rd_req;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_ack;
    logic [31:0] mem_rd_data;
    logic        mem_rd_data_valid;

    modport master (
        output mem_rd_req, mem_rd_addr,
        input  mem_rd_ack, mem_rd_data, mem_rd_data_valid
    );
    modport slave (
        input  mem_rd_req, mem_rd_addr,
        output mem_rd_ack, mem_rd_data, mem_rd_data_valid
    );
endinterface

// File: rtl/icache_fill_ctrl.sv
// icache refill controller: FSM, beat counter, line buffer, aborted flag
// and the memory request handshake.
module icache_fill_ctrl
    import icache_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_start,
    input  logic [31-OFF_BITS:0]   i_line,
    input  logic                   i_abort,
    icache_mem_if.master           mem,
    output logic                   o_idle,
    output logic                   o_aborted,
    output logic                   o_fill_done,
    output logic [LINE_BITS-1:0]   o_fill_line,
    output logic [31-OFF_BITS:0]   o_fill_addr
);

    fill_state_e         r_state;
    logic [1:0]          r_cnt;
    logic [31:0]         r_buf [WORDS_PER_LINE-1];
    logic                r_aborted;
    logic                r_req;
    logic [31-OFF_BITS:0] r_line;
    logic                w_beat;

    assign w_beat      = (r_state == ST_FILL) & mem.mem_rd_data_valid;
    assign o_fill_done = w_beat & (r_cnt == 2'd3);
    // The last beat bypasses the buffer so the line installs on that edge.
    assign o_fill_line = {mem.mem_rd_data, r_buf[2], r_buf[1], r_buf[0]};
    assign o_fill_addr = r_line;
    assign o_idle      = (r_state == ST_IDLE);
    assign o_aborted   = r_aborted;

    assign mem.mem_rd_req  = r_req;
    assign mem.mem_rd_addr = {r_line, {OFF_BITS{1'b0}}};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 2'd0;
            r_aborted <= 1'b0;
            r_req     <= 1'b0;
            r_line    <= '0;
            for (int i = 0; i < WORDS_PER_LINE - 1; i++) r_buf[i] <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    r_aborted <= 1'b0;
                    if (i_start) begin
                        r_line  <= i_line;
                        r_req   <= 1'b1;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (i_abort) r_aborted <= 1'b1;
                    if (mem.mem_rd_ack) begin
                        r_req   <= 1'b0;
                        r_state <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (i_abort) r_aborted <= 1'b1;
                    if (mem.mem_rd_data_valid) begin
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) r_state <= ST_IDLE;
                        else r_buf[r_cnt] <= mem.mem_rd_data;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/icache.sv
// icache top: direct-mapped read-only instruction cache, arrays and hit path.
// ICACHE_FILL_BYPASS_EN returns a matching line in its last refill beat.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = 6
) (
    input  logic          clk,
    input  logic          reset,
    icache_fetch_if.slave fetch,
    icache_mem_if.master  mem
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int LINE_W   = 32 - OFF_BITS;
    localparam int TAG_BITS = LINE_W - INDEX_BITS;

    logic                 r_valid [LINES];
    logic [TAG_BITS-1:0]  r_tag   [LINES];
    logic [LINE_BITS-1:0] r_data  [LINES];

    logic [LINE_W-1:0]     w_line;
    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_BITS-1:0]   w_tag;
    logic                  w_hit;
    logic                  w_req;
    logic                  w_idle;
    logic                  w_start;
    logic                  w_byp;
    logic                  w_fill_done;
    logic [LINE_BITS-1:0]  w_fill_line;
    logic [LINE_W-1:0]     w_fill_addr;
    logic [INDEX_BITS-1:0] w_fill_idx;
    logic [TAG_BITS-1:0]   w_fill_tag;

    assign w_line  = fetch.icache_pc_in[31:OFF_BITS];
    assign w_idx   = w_line[INDEX_BITS-1:0];
    assign w_tag   = w_line[LINE_W-1:INDEX_BITS];
    assign w_hit   = r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_req   = fetch.icache_rd_en & ~fetch.icache_abort;
    assign w_start = w_idle & w_req & ~w_hit;

    assign w_fill_idx = w_fill_addr[INDEX_BITS-1:0];
    assign w_fill_tag = w_fill_addr[LINE_W-1:INDEX_BITS];

`ifdef ICACHE_FILL_BYPASS_EN
    logic w_aborted;
    assign w_byp = w_fill_done & ~w_aborted & w_req & (w_line == w_fill_addr);
`else
    assign w_byp = 1'b0;
`endif

    icache_fill_ctrl u_fill (
        .clk         (clk),
        .reset       (reset),
        .i_start     (w_start),
        .i_line      (w_line),
        .i_abort     (fetch.icache_abort),
        .mem         (mem),
        .o_idle      (w_idle),
`ifdef ICACHE_FILL_BYPASS_EN
        .o_aborted   (w_aborted),
`else
        .o_aborted   (),
`endif
        .o_fill_done (w_fill_done),
        .o_fill_line (w_fill_line),
        .o_fill_addr (w_fill_addr)
    );

    // No hit-under-miss: lookups only report while the refill FSM is idle.
    assign fetch.icache_dout_valid = (w_idle & w_req & w_hit) | w_byp;
    assign fetch.icache_dout       = w_byp ? w_fill_line : r_data[w_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LINES; i++) begin
                r_valid[i] <= 1'b0;
                r_tag[i]   <= '0;
                r_data[i]  <= '0;
            end
        end else if (w_fill_done) begin
            r_valid[w_fill_idx] <= 1'b1;
            r_tag[w_fill_idx]   <= w_fill_tag;
            r_data[w_fill_idx]  <= w_fill_line;
        end
    end

endmodule

// File: tb/tb_icache.sv
// tb_icache: randomized scoreboard bench for icache with a memory responder
// and an address-level direct-mapped reference model.
module tb_icache;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    icache_fetch_if fif ();
    icache_mem_if   mif ();

    icache #(.INDEX_BITS(6)) dut (
        .clk   (clk),
        .reset (reset),
        .fetch (fif),
        .mem   (mif)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [127:0] exp_q [$];
    logic [27:0]  mexp_q [$];
    int fills_done = 0;
    int mem_reqs = 0;
    int mphase = 0;
    int mbeat = 0;
    logic [27:0] mline;
    logic [127:0] last_dout;

    bit          mv [64];
    logic [27:0] ml [64];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [27:0] line, input int i);
        logic [31:0] w;
        if (line == 28'h4) return 32'h11 * (i + 1);
        w = {line[15:0], 16'h0} ^ (line * 32'h9E37) ^ (32'h0101_0101 * (i + 1));
        return w;
    endfunction

    function automatic logic [127:0] line_words(input logic [27:0] line);
        return {mem_word(line, 3), mem_word(line, 2), mem_word(line, 1), mem_word(line, 0)};
    endfunction

    task automatic drive_beat();
        mif.mem_rd_data_valid = ($urandom_range(0, 3) != 0);
        mif.mem_rd_data = mif.mem_rd_data_valid ? mem_word(mline, mbeat) : $urandom;
    endtask

    // Memory responder: random ack delay, four beats with random gaps,
    // junk data_valid pulses while no fill is running.
    initial begin
        int wait_n;
        logic [27:0] e;
        mif.mem_rd_ack = 1'b0;
        mif.mem_rd_data_valid = 1'b0;
        mif.mem_rd_data = '0;
        wait_n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset) begin
                mif.mem_rd_ack = 1'b0;
                mif.mem_rd_data_valid = 1'b0;
                mphase = 0;
                mbeat = 0;
            end else begin
                case (mphase)
                    0: begin
                        mif.mem_rd_data_valid = ($urandom_range(0, 7) == 0);
                        mif.mem_rd_data = $urandom;
                        if (mif.mem_rd_req) begin
                            mem_reqs++;
                            mline = mif.mem_rd_addr[31:4];
                            if (mexp_q.size() == 0) begin
                                n_cmp++;
                                n_err++;
                                $display("FAIL unexpected_mem_req: got addr %h expected no request",
                                         mif.mem_rd_addr);
                            end else begin
                                e = mexp_q.pop_front();
                                chk("mem_rd_addr", mif.mem_rd_addr, {e, 4'h0});
                            end
                            wait_n = $urandom_range(0, 2);
                            if (wait_n == 0) begin
                                mif.mem_rd_ack = 1'b1;
                                mphase = 2;
                            end else mphase = 1;
                        end
                    end
                    1: begin
                        mif.mem_rd_data_valid = ($urandom_range(0, 3) == 0);
                        mif.mem_rd_data = $urandom;
                        wait_n--;
                        if (wait_n == 0) begin
                            mif.mem_rd_ack = 1'b1;
                            mphase = 2;
                        end
                    end
                    2: begin
                        mif.mem_rd_ack = 1'b0;
                        mbeat = 0;
                        mphase = 3;
                        drive_beat();
                    end
                    default: begin
                        if (mif.mem_rd_data_valid) mbeat++;
                        if (mbeat == 4) begin
                            mif.mem_rd_data_valid = 1'b0;
                            mphase = 0;
                            fills_done++;
                        end else drive_beat();
                    end
                endcase
            end
        end
    end

    // Monitor: every presented line is matched against the oldest expectation.
    initial begin
        logic [127:0] e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && fif.icache_dout_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_dout_valid: got line %h expected no response",
                             fif.icache_dout);
                end else begin
                    e = exp_q.pop_front();
                    chk("dout", fif.icache_dout, e);
                end
            end
        end
    end

    // mode 0: normal fetch, 1: rd_en with abort in the same cycle,
    // 2: miss aborted while the refill is outstanding.
    task automatic do_req(input logic [31:0] pc, input int mode_in);
        logic [27:0] line;
        int idx;
        bit hit;
        bit got;
        int cyc;
        int mode;
        int f0;
        line = pc[31:4];
        idx = int'(line[5:0]);
        hit = mv[idx] && (ml[idx] == line);
        mode = mode_in;
        if (mode == 2 && hit) mode = 0;
        fif.icache_pc_in = pc;
        if (mode == 1) begin
            fif.icache_rd_en = 1'b1;
            fif.icache_abort = 1'b1;
            @(negedge clk);
            chk("abort_no_valid", fif.icache_dout_valid, 0);
            @(posedge clk);
            #1;
            fif.icache_rd_en = 1'b0;
            fif.icache_abort = 1'b0;
        end else if (mode == 0) begin
            if (!hit) mexp_q.push_back(line);
            exp_q.push_back(line_words(line));
            fif.icache_rd_en = 1'b1;
            got = 0;
            cyc = 0;
            while (!got && cyc < 60) begin
                @(negedge clk);
                if (fif.icache_dout_valid === 1'b1) got = 1;
                else cyc++;
            end
            if (!got) begin
                n_cmp++;
                n_err++;
                $display("FAIL req_timeout: got no dout_valid in 60 cycles expected a response for pc %h", pc);
            end else if (hit) chk("hit_latency", cyc, 0);
            else chk("miss_latency_nonzero", (cyc > 0), 1);
            last_dout = fif.icache_dout;
            @(posedge clk);
            #1;
            fif.icache_rd_en = 1'b0;
            mv[idx] = 1'b1;
            ml[idx] = line;
        end else begin
            f0 = fills_done;
            mexp_q.push_back(line);
            fif.icache_rd_en = 1'b1;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
            fif.icache_abort = 1'b1;
            @(posedge clk);
            #1;
            fif.icache_abort = 1'b0;
            fif.icache_rd_en = 1'b0;
            cyc = 0;
            while (fills_done == f0 && cyc < 80) begin
                @(posedge clk);
                cyc++;
            end
            if (fills_done == f0) begin
                n_cmp++;
                n_err++;
                $display("FAIL abort_fill_timeout: got no completed refill expected one for pc %h", pc);
            end
            @(posedge clk);
            #1;
            mv[idx] = 1'b1;
            ml[idx] = line;
        end
    endtask

    initial begin
        int r;
        int cyc;
        logic [31:0] pc;
        fif.icache_pc_in = '0;
        fif.icache_rd_en = 1'b0;
        fif.icache_abort = 1'b0;
        for (int i = 0; i < 64; i++) begin
            mv[i] = 1'b0;
            ml[i] = '0;
        end
        repeat (2) @(negedge clk);
        chk("reset_dout_valid", fif.icache_dout_valid, 0);
        chk("reset_mem_rd_req", mif.mem_rd_req, 0);
        chk("reset_mem_rd_addr", mif.mem_rd_addr, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        do_req(32'h0000_0040, 0);
        chk("cold_miss_line", last_dout, 128'h00000044_00000033_00000022_00000011);

        do_req(32'h0000_0054, 0);
        r = mem_reqs;
        do_req(32'h0000_0048, 0);
        do_req(32'h0000_0050, 0);
        chk("stream_no_req", mem_reqs, r);

        do_req(32'h0000_0100, 2);
        r = mem_reqs;
        do_req(32'h0000_0100, 0);
        chk("abort_line_installed", mem_reqs, r);

        r = mem_reqs;
        do_req(32'h0000_0440, 0);
        do_req(32'h0000_0040, 0);
        chk("conflict_refills", mem_reqs - r, 2);

        do_req(32'h0000_0040, 1);

        for (int n = 0; n < 300; n++) begin
            pc = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 4) | $urandom_range(0, 15);
            r = $urandom_range(0, 9);
            do_req(pc, (r == 0) ? 1 : (r == 1) ? 2 : 0);
        end

        do_req(32'h0000_0040, 0);
        exp_q.push_back(line_words(28'h1234));
        mexp_q.push_back(28'h1234);
        fif.icache_pc_in = 32'h0001_2340;
        fif.icache_rd_en = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(mphase == 3 && mbeat == 2) && cyc < 60);
        if (cyc >= 60) begin
            n_cmp++;
            n_err++;
            $display("FAIL fill_beat2_timeout: got phase %0d beat %0d expected beat 2 of a fill", mphase, mbeat);
        end
        reset = 1'b0;
        #1;
        chk("rst_mid_fill_req", mif.mem_rd_req, 0);
        chk("rst_mid_fill_valid", fif.icache_dout_valid, 0);
        fif.icache_rd_en = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 64; i++) mv[i] = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        r = mem_reqs;
        do_req(32'h0000_0040, 0);
        chk("miss_after_reset", mem_reqs - r, 1);

        repeat (4) @(posedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("mem_exp_drained", mexp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
